mmio_timer: RTL and testbench
=============================

# mmio_timer

Memory-mapped timer peripheral that answers the CPU's data-memory port on the memory-access stage, beside `Data_memory`. It decodes loads and stores in a 32-byte window, keeps a prescaled 32-bit up-counter with compare-match, and raises a level interrupt. Reads are combinational, so load data is valid in the same cycle, exactly as `Data_memory` returns it to the MEM/WB register. Writes commit on the clock edge.

## Interface
- BASE_ADDR, 32'h0000_1000, window base; must be 32-byte aligned.
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- MemRead  in  1  load request from the EX/MEM stage
- MemWrite  in  1  store request from the EX/MEM stage
- funct3  in  3  access size: 000 B, 001 H, 010 W, 100 BU, 101 HU
- Address  in  32  byte address (the ALU result)
- Write_data  in  32  store data, right-aligned as it leaves the register file
- Read_data  out  32  load data, extended per funct3; 0 when not selected or MemRead=0
- sel  out  1  Address[31:5]==BASE_ADDR[31:5]; system uses it to mux Read_data against Data_memory
- irq  out  1  STATUS.match & CTRL.irq_en

## Operation
- Register map (offset = Address[4:0]):
  - 0x00 CTRL: bit0 enable, bit1 auto_reload, bit2 irq_en, bits[15:8] prescale; other bits read 0.
  - 0x04 COUNT: RW.
  - 0x08 COMPARE: RW.
  - 0x0C STATUS: bit0 match; write-1-to-clear; other bits read 0.
- Unmapped offsets 0x10–0x1F read 0 and ignore writes.
- Sub-word access uses byte lanes selected by Address[1:0]:
  - Stores merge only the addressed byte or halfword; other bytes keep their value.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - Halfword access with Address[0]=1 is misaligned: the write is ignored and the read returns 0.
  - Word access with Address[1:0]≠0 is also misaligned: the write is ignored and the read returns 0.
- Prescaler: internal 8-bit pre_cnt.
  - When enable=1: if pre_cnt==prescale, set pre_cnt to 0 and assert tick for one cycle; otherwise increment pre_cnt.
  - prescale=0 therefore ticks every cycle.
- On tick:
  - If COUNT==COMPARE: set match; COUNT becomes 0 if auto_reload=1, otherwise COUNT+1.
  - Otherwise COUNT becomes COUNT+1.
  - Arithmetic is modulo 2^32; 0xFFFF_FFFF wraps to 0.
- enable=0: pre_cnt is held at 0 and COUNT holds its value.
- A store to CTRL that clears enable also zeroes pre_cnt on the same edge.
- Simultaneous events:
  - A store to COUNT in the same cycle as a tick: the stored value wins, and no match is evaluated that cycle.
  - A W1C to STATUS in the same cycle as a new match: the set wins and match stays 1.
  - A store to COMPARE in the same cycle as a tick: the tick compares against the old COMPARE.
  - MemRead and MemWrite both high: the store commits, and Read_data returns the pre-store value.
- Reset: CTRL=0, COUNT=0, COMPARE=0xFFFF_FFFF, STATUS=0, pre_cnt=0. Consequently irq=0, and sel and Read_data follow their inputs combinationally. Reset asserted mid-count clears everything on that edge and overrides any store in the same cycle.

## Timing
- Read path: purely combinational from Address, funct3, MemRead and register state to Read_data; zero-cycle latency.
- A store is visible to a load issued in the next cycle.
- COUNT increments on the edge after a tick cycle.
- irq rises on the edge where match is set (combinational from registers) and falls on the edge after the W1C store.
- With enable first set at edge E and prescale=P, the first COUNT increment occurs at edge E+P+1.
- No stalls: the block never backpressures the pipeline.

## Test plan
- Reset then read: LW of 0x1008 → Read_data=0xFFFF_FFFF, sel=1; LW of 0x100C → 0; irq=0.
- Prescale: SW 0x0000_0301 to CTRL (enable, P=3) → COUNT reads 1 after 4 cycles and 5 after 20 cycles.
- Match with auto-reload:
  - Stimulus: COMPARE=5; CTRL=0x0000_0007 with P=0.
  - Response: match=1 and irq=1 on the edge where COUNT goes 5→0.
  - Then SW 1 to STATUS → irq=0 next cycle.
- Byte lanes:
  - Stimulus: SW 0x1122_3344 to COMPARE, then SB 0xAA to 0x100A.
  - Response: LW returns 0x11AA_3344; LB 0x100A returns 0xFFFF_FFAA; LBU returns 0x0000_00AA; LH 0x1009 returns 0 and SH 0x1009 leaves COMPARE unchanged.
- Collisions:
  - SW to COUNT coincident with a tick → the stored value holds.
  - W1C coincident with a match → match stays 1.
  - rst asserted mid-count with a store pending → all registers return to reset values.
- Decode: LW of 0x2004 → sel=0, Read_data=0; SW to 0x1014 → no register changes.

Source files
------------

// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped prescaled 32-bit up-counter with compare-match interrupt,
// decoded in a 32-byte window beside the data memory on the MEM stage.
module mmio_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] Address,
    input  logic [31:0] Write_data,
    output logic [31:0] Read_data,
    output logic        sel,
    output logic        irq
);
    logic        enable_q, enable_d, auto_reload_q, auto_reload_d;
    logic        irq_en_q, irq_en_d, match_q, match_d;
    logic [7:0]  prescale_q, prescale_d, pre_cnt_q, pre_cnt_d;
    logic [31:0] count_q, count_d, compare_q, compare_d;
    logic [1:0]  lane;
    logic [2:0]  idx;
    logic        valid, is_b, is_h, is_w, ok, we, tick, hit, count_wr, w1c;
    logic [3:0]  bmask;
    logic [31:0] mask, wsh, rword, merged, rsh;

    always_comb begin
        sel = Address[31:5] == BASE_ADDR[31:5];
        lane = Address[1:0];
        idx = Address[4:2];
        valid = funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010 ||
                funct3 == 3'b100 || funct3 == 3'b101;
        is_b = funct3[1:0] == 2'b00;
        is_h = funct3[1:0] == 2'b01;
        is_w = funct3[1:0] == 2'b10;
        ok = sel && valid && (is_b || (is_h && !lane[0]) || (is_w && lane == 2'b00));
        bmask = is_w ? 4'hF : is_h ? (4'h3 << lane) : (4'h1 << lane);
        mask = {{8{bmask[3]}}, {8{bmask[2]}}, {8{bmask[1]}}, {8{bmask[0]}}};
        wsh = Write_data << {lane, 3'b000};
        rword = idx == 3'd0 ? {16'b0, prescale_q, 5'b0, irq_en_q, auto_reload_q, enable_q} :
                idx == 3'd1 ? count_q :
                idx == 3'd2 ? compare_q :
                idx == 3'd3 ? {31'b0, match_q} : 32'b0;
        merged = (rword & ~mask) | (wsh & mask);
        we = MemWrite && ok;
        // Loads see register state before any same-cycle store commits.
        rsh = rword >> {lane, 3'b000};
        Read_data = !(MemRead && ok) ? 32'b0 :
                    is_w ? rword :
                    is_h ? (funct3[2] ? {16'b0, rsh[15:0]} : {{16{rsh[15]}}, rsh[15:0]}) :
                    (funct3[2] ? {24'b0, rsh[7:0]} : {{24{rsh[7]}}, rsh[7:0]});
        irq = match_q && irq_en_q;
    end

    always_comb begin
        tick = enable_q && pre_cnt_q == prescale_q;
        hit = tick && count_q == compare_q;
        count_wr = we && idx == 3'd1;
        w1c = we && idx == 3'd3 && mask[0] && wsh[0];
        enable_d = (we && idx == 3'd0) ? merged[0] : enable_q;
        auto_reload_d = (we && idx == 3'd0) ? merged[1] : auto_reload_q;
        irq_en_d = (we && idx == 3'd0) ? merged[2] : irq_en_q;
        prescale_d = (we && idx == 3'd0) ? merged[15:8] : prescale_q;
        pre_cnt_d = (!enable_q || !enable_d || tick) ? 8'd0 : pre_cnt_q + 8'd1;
        count_d = count_wr ? merged :
                  tick ? ((hit && auto_reload_q) ? 32'd0 : count_q + 32'd1) : count_q;
        compare_d = (we && idx == 3'd2) ? merged : compare_q;
        match_d = (hit && !count_wr) || (match_q && !w1c);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            enable_q <= 1'b0;
            auto_reload_q <= 1'b0;
            irq_en_q <= 1'b0;
            prescale_q <= 8'd0;
            pre_cnt_q <= 8'd0;
            count_q <= 32'd0;
            compare_q <= 32'hFFFF_FFFF;
            match_q <= 1'b0;
        end else begin
            enable_q <= enable_d;
            auto_reload_q <= auto_reload_d;
            irq_en_q <= irq_en_d;
            prescale_q <= prescale_d;
            pre_cnt_q <= pre_cnt_d;
            count_q <= count_d;
            compare_q <= compare_d;
            match_q <= match_d;
        end
    end
endmodule

// File: tb/tb_mmio_timer.sv
// tb_mmio_timer: directed self-checking bench for mmio_timer.
module tb_mmio_timer;
    localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010, BU = 3'b100, HU = 3'b101;
    localparam logic [31:0] CTRL = 32'h1000, COUNT = 32'h1004, CMP = 32'h1008, STAT = 32'h100C;
    logic        clk = 1'b0, rst = 1'b1, MemRead = 1'b0, MemWrite = 1'b0;
    logic [2:0]  funct3 = W;
    logic [31:0] Address = 32'b0, Write_data = 32'b0, Read_data;
    logic        sel, irq;
    int n_run = 0, n_fail = 0;

    mmio_timer dut (
        .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite), .funct3(funct3),
        .Address(Address), .Write_data(Write_data), .Read_data(Read_data), .sel(sel), .irq(irq)
    );

    always #50 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
        Address = a;
        Write_data = d;
        funct3 = f;
        MemWrite = 1'b1;
        cycles(1);
        MemWrite = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [2:0] f, input logic [31:0] exp);
        Address = a;
        funct3 = f;
        MemRead = 1'b1;
        #1;
        check(tag, Read_data, exp);
        MemRead = 1'b0;
    endtask

    initial begin
        cycles(2);
        rst = 1'b0;
        rd("rst_cmp", CMP, W, 32'hFFFF_FFFF);
        check("rst_sel", {31'b0, sel}, 32'd1);
        rd("rst_stat", STAT, W, 32'd0);
        rd("rst_ctrl", CTRL, W, 32'd0);
        rd("rst_count", COUNT, W, 32'd0);
        check("rst_irq", {31'b0, irq}, 32'd0);
        Address = CMP;
        #1;
        check("no_memread", Read_data, 32'd0);
        // prescale 3: first increment 4 edges after enable
        wr(CTRL, 32'h0000_0301, W);
        cycles(3);
        rd("p3_e3", COUNT, W, 32'd0);
        cycles(1);
        rd("p3_e4", COUNT, W, 32'd1);
        cycles(16);
        rd("p3_e20", COUNT, W, 32'd5);
        wr(CTRL, 32'd0, W);
        cycles(5);
        rd("disable_hold", COUNT, W, 32'd5);
        // byte lanes
        wr(CMP, 32'h1122_3344, W);
        wr(32'h100A, 32'h0000_00AA, B);
        rd("lw_merge", CMP, W, 32'h11AA_3344);
        rd("lb_sext", 32'h100A, B, 32'hFFFF_FFAA);
        rd("lbu", 32'h100A, BU, 32'h0000_00AA);
        rd("lh_misalign", 32'h1009, H, 32'd0);
        rd("lh_hi", 32'h100A, H, 32'h0000_11AA);
        rd("lhu_lo", CMP, HU, 32'h0000_3344);
        wr(32'h1009, 32'h0000_BEEF, H);
        rd("sh_misalign", CMP, W, 32'h11AA_3344);
        wr(32'h100A, 32'hDEAD_BEEF, W);
        rd("sw_misalign", CMP, W, 32'h11AA_3344);
        wr(32'h100A, 32'h0000_8001, H);
        rd("sh_merge", CMP, W, 32'h8001_3344);
        rd("lh_neg", 32'h100A, H, 32'hFFFF_8001);
        rd("lb_top", 32'h100B, B, 32'hFFFF_FF80);
        // decode
        rd("out_of_window", 32'h2004, W, 32'd0);
        check("out_sel", {31'b0, sel}, 32'd0);
        wr(32'h1014, 32'h1234_5678, W);
        rd("unmapped_rd", 32'h1014, W, 32'd0);
        rd("unmapped_cnt", COUNT, W, 32'd5);
        rd("unmapped_cmp", CMP, W, 32'h8001_3344);
        rd("unmapped_ctrl", CTRL, W, 32'd0);
        // match with auto-reload, P=0
        wr(COUNT, 32'd0, W);
        wr(CMP, 32'd5, W);
        wr(CTRL, 32'd7, W);
        rd("ar_e0", COUNT, W, 32'd0);
        cycles(5);
        rd("ar_e5", COUNT, W, 32'd5);
        rd("ar_e5_stat", STAT, W, 32'd0);
        check("ar_e5_irq", {31'b0, irq}, 32'd0);
        cycles(1);
        rd("ar_reload", COUNT, W, 32'd0);
        rd("ar_match", STAT, W, 32'd1);
        check("ar_irq", {31'b0, irq}, 32'd1);
        wr(STAT, 32'd1, W);
        check("w1c_irq", {31'b0, irq}, 32'd0);
        rd("w1c_stat", STAT, W, 32'd0);
        rd("w1c_count", COUNT, W, 32'd1);
        cycles(4);
        rd("pre_rematch", COUNT, W, 32'd5);
        wr(STAT, 32'd1, W);
        rd("w1c_vs_set", STAT, W, 32'd1);
        check("w1c_vs_set_irq", {31'b0, irq}, 32'd1);
        rd("w1c_vs_set_cnt", COUNT, W, 32'd0);
        // simultaneous load and store returns the pre-store value
        Address = STAT;
        funct3 = W;
        Write_data = 32'd1;
        MemRead = 1'b1;
        MemWrite = 1'b1;
        #1;
        check("rw_prestore", Read_data, 32'd1);
        cycles(1);
        MemRead = 1'b0;
        MemWrite = 1'b0;
        rd("rw_committed", STAT, W, 32'd0);
        // store to COUNT beats a tick and suppresses the match
        wr(CTRL, 32'd0, W);
        wr(COUNT, 32'd5, W);
        wr(CTRL, 32'd7, W);
        rd("coll_pre", COUNT, W, 32'd5);
        wr(COUNT, 32'h40, W);
        rd("coll_store", COUNT, W, 32'h40);
        rd("coll_nomatch", STAT, W, 32'd0);
        cycles(1);
        rd("coll_next", COUNT, W, 32'h41);
        // 32-bit wrap without auto-reload
        wr(CTRL, 32'd0, W);
        wr(CMP, 32'd0, W);
        wr(COUNT, 32'hFFFF_FFFF, W);
        wr(CTRL, 32'd1, W);
        rd("wrap_pre", COUNT, W, 32'hFFFF_FFFF);
        cycles(1);
        rd("wrap_zero", COUNT, W, 32'd0);
        cycles(1);
        rd("wrap_noreload", COUNT, W, 32'd1);
        rd("wrap_match", STAT, W, 32'd1);
        check("wrap_irq_off", {31'b0, irq}, 32'd0);
        // reset mid-count overrides a pending store
        wr(CTRL, 32'd5, W);
        check("pre_rst_irq", {31'b0, irq}, 32'd1);
        cycles(2);
        rst = 1'b1;
        Address = CMP;
        Write_data = 32'h1234;
        funct3 = W;
        MemWrite = 1'b1;
        cycles(1);
        rst = 1'b0;
        MemWrite = 1'b0;
        rd("mid_rst_ctrl", CTRL, W, 32'd0);
        rd("mid_rst_count", COUNT, W, 32'd0);
        rd("mid_rst_cmp", CMP, W, 32'hFFFF_FFFF);
        rd("mid_rst_stat", STAT, W, 32'd0);
        check("mid_rst_irq", {31'b0, irq}, 32'd0);
        cycles(3);
        rd("mid_rst_idle", COUNT, W, 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
